// File: rtl/mux_bus_responder_pkg.sv
// Shared encodings for the multiplexed-bus responder: bus phases, memory
// handshake states and the R/W bit polarity driven by the CPU.
package bus_resp_defs;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mux_bus_responder_mem.sv
// Memory-side req/ack handshake: holds one transaction at a time, abandons it
// after ACK_TIMEOUT unacknowledged cycles, captures read data, counts drops.
module mem_req_fsm
    import bus_resp_defs::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch,
    input  logic             launch_we,
    input  logic [15:0]      launch_addr,
    input  logic [7:0]       launch_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] overrun_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    mem_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rd_q, rd_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wait_d  = wait_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        case (state_q)
            M_IDLE: begin
                // A stray mem_ack here is deliberately ignored.
                if (launch) begin
                    state_d = M_WAIT;
                    req_d   = 1'b1;
                    we_d    = launch_we;
                    addr_d  = launch_addr;
                    wdata_d = launch_wdata;
                    wait_d  = '0;
                end
            end
            M_WAIT: begin
                // Any launch seen while busy is dropped, even if the ack lands now.
                if (launch) begin
                    ovr_d = (&ovr_q) ? ovr_q : ovr_q + 1'b1;
                end
                if (mem_ack) begin
                    state_d = M_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rd_d = mem_rdata;
                    end
                end else if (wait_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = M_IDLE;
                    req_d   = 1'b0;
                    tmo_d   = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = M_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            wait_q  <= '0;
            ovr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wait_q  <= wait_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign rd_data       = rd_q;
    assign overrun_count = ovr_q;
    assign timeout_count = tmo_q;

endmodule

// File: rtl/mux_bus_responder.sv
// Target side of the CPU's time-multiplexed bus: rebuilds address, R/W and
// write data from the two half-phases and hands each access to mem_req_fsm.
module mux_bus_responder
    import bus_resp_defs::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       addr_in,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             data_oe,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] overrun_count,
    output logic [CNT_W-1:0] timeout_count
);

    // ph_q holds the half-phase captured at the most recent edge; resetting it
    // to PH_LO makes the first edge after release a high-byte capture.
    phase_e     ph_q, ph_d;
    logic [7:0] addr_hi_q, addr_hi_d;
    logic [7:0] addr_lo_q, addr_lo_d;
    logic       rw_q, rw_d;
    logic       wr_pending_q, wr_pending_d;
    logic       data_oe_q, data_oe_d;

    logic        launch;
    logic        launch_we;
    logic [15:0] launch_addr;
    logic [7:0]  launch_wdata;

    always_comb begin
        ph_d         = (ph_q == PH_HI) ? PH_LO : PH_HI;
        addr_hi_d    = addr_hi_q;
        addr_lo_d    = addr_lo_q;
        rw_d         = rw_q;
        wr_pending_d = wr_pending_q;
        data_oe_d    = data_oe_q;
        launch       = 1'b0;
        launch_we    = 1'b0;
        launch_addr  = {addr_hi_q, addr_in};
        launch_wdata = data_in;
        if (ph_d == PH_HI) begin
            addr_hi_d = addr_in;
            // Write data only appears one half-phase after the R/W bit.
            if (wr_pending_q && (rw_q == RW_WRITE)) begin
                launch       = 1'b1;
                launch_we    = 1'b1;
                launch_addr  = {addr_hi_q, addr_lo_q};
                wr_pending_d = 1'b0;
            end
        end else begin
            addr_lo_d = addr_in;
            rw_d      = data_in[0];
            data_oe_d = (data_in[0] == RW_READ);
            if (data_in[0] == RW_READ) begin
                launch = 1'b1;
            end else begin
                wr_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q         <= PH_LO;
            addr_hi_q    <= '0;
            addr_lo_q    <= '0;
            rw_q         <= RW_READ;
            wr_pending_q <= 1'b0;
            data_oe_q    <= 1'b0;
        end else begin
            ph_q         <= ph_d;
            addr_hi_q    <= addr_hi_d;
            addr_lo_q    <= addr_lo_d;
            rw_q         <= rw_d;
            wr_pending_q <= wr_pending_d;
            data_oe_q    <= data_oe_d;
        end
    end

    assign data_oe = data_oe_q;

    mem_req_fsm #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_mem_req_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch       (launch),
        .launch_we    (launch_we),
        .launch_addr  (launch_addr),
        .launch_wdata (launch_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .rd_data      (data_out),
        .overrun_count(overrun_count),
        .timeout_count(timeout_count)
    );

endmodule
